// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the fpadder/fpsubber datapaths:
// field widths, the canonical quiet NaN, FSM states and the unpacked-operand record.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int GRS_W   = 3;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  // Denormals flush to zero; the hidden bit is only set for normal numbers.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic negate);
    fp_unpacked_t u;
    u.sign    = v[31] ^ negate;
    u.exp     = v[MAN_W+EXP_W-1:MAN_W];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == '1) && (v[MAN_W-1:0] == '0);
    u.is_nan  = (u.exp == '1) && (v[MAN_W-1:0] != '0);
    u.man     = u.is_zero ? '0 : {1'b1, v[MAN_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fpsubber_if.sv
// Operand/result/ready bus shared by the fp add/subtract units.
interface fpsubber_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] diff;
  logic        ready;

  modport master (output start, a, b, input busy, diff, ready);
  modport slave  (input start, a, b, output busy, diff, ready);
endinterface

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc (
  input  logic [27:0] value,
  output logic [4:0]  count
);
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end
endmodule

// File: rtl/fpsubber.sv
// Multi-cycle IEEE-754 single-precision subtractor, diff = a - b.
// state | meaning: IDLE wait start | UNPACK split fields | ALIGN swap+shift | ADDSUB magnitudes | NORM normalise | ROUND RNE, publish
module fpsubber
  import fp_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  fpsubber_if.slave bus
);
  localparam int MW = MAN_W + 1 + GRS_W;
  localparam logic [EXP_W-1:0]  SHIFT_MAX = EXP_W'(MW);
  localparam logic signed [9:0] EXP_LIM   = 10'(EXP_MAX);

  state_t state, state_nxt;

  logic [31:0]      a_r, b_r;
  fp_unpacked_t     ua_r, ub_r;
  logic             spec_r;
  logic [31:0]      spec_val_r;
  logic             sx_r, sy_r;
  logic [EXP_W-1:0] ex_r;
  logic [MW-1:0]    mx_r, my_r;
  logic             sign_r, eff_sub_r;
  logic [9:0]       exp_r, nexp_r;
  logic [MW:0]      sum_r;
  logic [MW-1:0]    nman_r;
  logic             zero_r;
  logic             busy_r, ready_r;
  logic [31:0]      diff_r;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = UNPACK;
      UNPACK:  state_nxt = ALIGN;
      ALIGN:   state_nxt = ADDSUB;
      ADDSUB:  state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Specials: ub_r already carries the inverted sign of b.
  logic        spec_n;
  logic [31:0] spec_val_n;
  always_comb begin
    spec_n     = ua_r.is_nan | ub_r.is_nan | ua_r.is_inf | ub_r.is_inf;
    spec_val_n = QNAN;
    if (ua_r.is_nan || ub_r.is_nan)                            spec_val_n = QNAN;
    else if (ua_r.is_inf && ub_r.is_inf && ua_r.sign != ub_r.sign) spec_val_n = QNAN;
    else if (ua_r.is_inf) spec_val_n = {ua_r.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                  spec_val_n = {ub_r.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // Alignment: the larger magnitude becomes X; equal magnitudes keep a as X.
  logic             x_is_a, sx_n, sy_n;
  logic [EXP_W-1:0] ex_n, ey_n, ediff;
  logic [MW-1:0]    mx_n, y_ext, y_sh, y_al;
  always_comb begin
    x_is_a = {ua_r.exp, ua_r.man} >= {ub_r.exp, ub_r.man};
    sx_n   = x_is_a ? ua_r.sign : ub_r.sign;
    sy_n   = x_is_a ? ub_r.sign : ua_r.sign;
    ex_n   = x_is_a ? ua_r.exp  : ub_r.exp;
    ey_n   = x_is_a ? ub_r.exp  : ua_r.exp;
    mx_n   = x_is_a ? (ua_r.is_zero ? '0 : {ua_r.man, {GRS_W{1'b0}}})
                    : (ub_r.is_zero ? '0 : {ub_r.man, {GRS_W{1'b0}}});
    y_ext  = x_is_a ? (ub_r.is_zero ? '0 : {ub_r.man, {GRS_W{1'b0}}})
                    : (ua_r.is_zero ? '0 : {ua_r.man, {GRS_W{1'b0}}});
    ediff  = ex_n - ey_n;
    y_sh   = '0;
    if (ediff >= SHIFT_MAX) begin
      y_al = {{(MW-1){1'b0}}, |y_ext};
    end else begin
      y_sh = y_ext >> ediff;
      y_al = {y_sh[MW-1:1], y_sh[0] | (|(y_ext & ~({MW{1'b1}} << ediff)))};
    end
  end

  logic [MW:0] sum_n;
  assign sum_n = (sx_r != sy_r) ? ({1'b0, mx_r} - {1'b0, my_r})
                                : ({1'b0, mx_r} + {1'b0, my_r});

  logic [4:0]    lz;
  logic [MW-1:0] nman_n;
  logic [9:0]    nexp_n;

  fp_lzc u_lzc (
    .value (sum_r),
    .count (lz)
  );

  always_comb begin
    if (sum_r[MW]) begin
      nman_n = {sum_r[MW:2], sum_r[1] | sum_r[0]};
      nexp_n = exp_r + 10'd1;
    end else begin
      nman_n = sum_r[MW-1:0] << (lz - 5'd1);
      nexp_n = exp_r - 10'(lz) + 10'd1;
    end
  end

  // Round to nearest even on the guard bit; a mantissa carry renormalises.
  logic              round_up;
  logic [MAN_W+1:0]  rman;
  logic [MAN_W-1:0]  frac;
  logic [9:0]        rexp;
  logic [31:0]       result_n;
  always_comb begin
    round_up = nman_r[GRS_W-1] & ((|nman_r[GRS_W-2:0]) | nman_r[GRS_W]);
    rman     = {1'b0, nman_r[MW-1:GRS_W]} + (MAN_W+2)'(round_up);
    if (rman[MAN_W+1]) begin
      frac = rman[MAN_W:1];
      rexp = nexp_r + 10'd1;
    end else begin
      frac = rman[MAN_W-1:0];
      rexp = nexp_r;
    end
    if (spec_r)                      result_n = spec_val_r;
    else if (zero_r)                 result_n = {sign_r & ~eff_sub_r, 31'b0};
    else if ($signed(rexp) >= EXP_LIM) result_n = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if ($signed(rexp) < 10'sd1)   result_n = {sign_r, 31'b0};
    else                             result_n = {sign_r, rexp[EXP_W-1:0], frac};
  end

  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (bus.start) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
      UNPACK: begin
        ua_r <= fp_unpack(a_r, 1'b0);
        ub_r <= fp_unpack(b_r, 1'b1);
      end
      ALIGN: begin
        spec_r     <= spec_n;
        spec_val_r <= spec_val_n;
        sx_r       <= sx_n;
        sy_r       <= sy_n;
        ex_r       <= ex_n;
        mx_r       <= mx_n;
        my_r       <= y_al;
      end
      ADDSUB: begin
        sign_r    <= sx_r;
        eff_sub_r <= sx_r ^ sy_r;
        exp_r     <= {2'b00, ex_r};
        sum_r     <= sum_n;
      end
      NORM: begin
        nman_r <= nman_n;
        nexp_r <= nexp_n;
        zero_r <= (sum_r == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      diff_r  <= '0;
    end else begin
      ready_r <= 1'b0;
      if (state == IDLE && bus.start) busy_r <= 1'b1;
      if (state == ROUND) begin
        busy_r  <= 1'b0;
        ready_r <= 1'b1;
        diff_r  <= result_n;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.ready = ready_r;
  assign bus.diff  = diff_r;

endmodule

// File: tb/tb_fpsubber.sv
// Directed bench for fpsubber: hand-computed results, latency and handshake behaviour.
module tb_fpsubber;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fpsubber_if bus ();

  fpsubber dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output int lat,
                       output logic busy_early, output logic busy_rdy);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    busy_early = bus.busy;
    lat = -1;
    res = 32'hxxxx_xxxx;
    busy_rdy = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (bus.ready) begin
        lat = i;
        res = bus.diff;
        busy_rdy = bus.busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b expected 0", bus.ready); end
    checks++; if (bus.diff !== 32'h0) begin failures++; $display("FAIL reset_diff got %h expected 00000000", bus.diff); end
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat; logic be, br;
    do_op(32'h4040_0000, 32'h3FC0_0000, r, lat, be, br);
    checks++; if (r !== 32'h3FC0_0000) begin failures++; $display("FAIL basic_3m1p5 got %h expected 3fc00000", r); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got %0d expected 5", lat); end
    checks++; if (be !== 1'b1) begin failures++; $display("FAIL basic_busy_high got %b expected 1", be); end
    checks++; if (br !== 1'b0) begin failures++; $display("FAIL basic_busy_at_ready got %b expected 0", br); end
    do_op(32'h3FC0_0000, 32'h4040_0000, r, lat, be, br);
    checks++; if (r !== 32'hBFC0_0000) begin failures++; $display("FAIL basic_neg got %h expected bfc00000", r); end
    do_op(32'h4040_0000, 32'h4040_0000, r, lat, be, br);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL basic_x_minus_x got %h expected 00000000", r); end
    do_op(32'h8000_0000, 32'h0000_0000, r, lat, be, br);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL zero_neg_minus_pos got %h expected 80000000", r); end
    do_op(32'h0000_0000, 32'h0000_0000, r, lat, be, br);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL zero_pos_minus_pos got %h expected 00000000", r); end
  endtask

  task automatic test_rounding();
    logic [31:0] r; int lat; logic be, br;
    do_op(32'h3F80_0000, 32'h3380_0000, r, lat, be, br);
    checks++; if (r !== 32'h3F7F_FFFF) begin failures++; $display("FAIL round_exact got %h expected 3f7fffff", r); end
    do_op(32'h3F80_0000, 32'h3300_0000, r, lat, be, br);
    checks++; if (r !== 32'h3F80_0000) begin failures++; $display("FAIL round_tie_even got %h expected 3f800000", r); end
    do_op(32'h3F80_0000, 32'h0080_0000, r, lat, be, br);
    checks++; if (r !== 32'h3F80_0000) begin failures++; $display("FAIL round_far_sticky got %h expected 3f800000", r); end
    do_op(32'h4000_0000, 32'h3F80_0000, r, lat, be, br);
    checks++; if (r !== 32'h3F80_0000) begin failures++; $display("FAIL two_minus_one got %h expected 3f800000", r); end
    do_op(32'h0000_0001, 32'h0000_0000, r, lat, be, br);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL denorm_flush got %h expected 00000000", r); end
  endtask

  task automatic test_specials();
    logic [31:0] r; int lat; logic be, br;
    do_op(32'h7F80_0000, 32'h7F80_0000, r, lat, be, br);
    checks++; if (r !== 32'h7FC0_0000) begin failures++; $display("FAIL inf_minus_inf got %h expected 7fc00000", r); end
    do_op(32'hFF7F_FFFF, 32'h7F7F_FFFF, r, lat, be, br);
    checks++; if (r !== 32'hFF80_0000) begin failures++; $display("FAIL overflow_neg_inf got %h expected ff800000", r); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL special_latency got %0d expected 5", lat); end
    do_op(32'h7FC0_0001, 32'h3F80_0000, r, lat, be, br);
    checks++; if (r !== 32'h7FC0_0000) begin failures++; $display("FAIL nan_input got %h expected 7fc00000", r); end
    do_op(32'hFF80_0000, 32'h3F80_0000, r, lat, be, br);
    checks++; if (r !== 32'hFF80_0000) begin failures++; $display("FAIL inf_minus_finite got %h expected ff800000", r); end
    do_op(32'h3F80_0000, 32'h7F80_0000, r, lat, be, br);
    checks++; if (r !== 32'hFF80_0000) begin failures++; $display("FAIL finite_minus_inf got %h expected ff800000", r); end
    do_op(32'h7F80_0000, 32'hFF80_0000, r, lat, be, br);
    checks++; if (r !== 32'h7F80_0000) begin failures++; $display("FAIL inf_minus_neginf got %h expected 7f800000", r); end
  endtask

  task automatic test_ignore_start();
    int readies = 0;
    int ready_cyc = -1;
    logic [31:0] r = 32'h0;
    bus.a = 32'h4040_0000;
    bus.b = 32'h3FC0_0000;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    bus.a = 32'h3F80_0000;
    bus.b = 32'h3F80_0000;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 3; c <= 14; c++) begin
      @(posedge clock); #1;
      if (bus.ready) begin
        readies++;
        if (ready_cyc < 0) begin ready_cyc = c; r = bus.diff; end
      end
    end
    checks++; if (readies !== 1) begin failures++; $display("FAIL ignore_ready_count got %0d expected 1", readies); end
    checks++; if (ready_cyc !== 5) begin failures++; $display("FAIL ignore_latency got %0d expected 5", ready_cyc); end
    checks++; if (r !== 32'h3FC0_0000) begin failures++; $display("FAIL ignore_result got %h expected 3fc00000", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; logic be, br;
    do_op(32'h4040_0000, 32'h3FC0_0000, r, lat, be, br);
    checks++; if (r !== 32'h3FC0_0000) begin failures++; $display("FAIL b2b_first got %h expected 3fc00000", r); end
    do_op(32'h3FC0_0000, 32'h4040_0000, r, lat, be, br);
    checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_latency got %0d expected 5", lat); end
    checks++; if (r !== 32'hBFC0_0000) begin failures++; $display("FAIL b2b_second got %h expected bfc00000", r); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; int lat; logic be, br;
    int readies = 0;
    bus.a = 32'h4040_0000;
    bus.b = 32'h3FC0_0000;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b expected 0", bus.busy); end
    checks++; if (bus.diff !== 32'h0) begin failures++; $display("FAIL abort_diff got %h expected 00000000", bus.diff); end
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (bus.ready) readies++;
    end
    checks++; if (readies !== 0) begin failures++; $display("FAIL abort_no_ready got %0d expected 0", readies); end
    do_op(32'h4040_0000, 32'h3FC0_0000, r, lat, be, br);
    checks++; if (r !== 32'h3FC0_0000) begin failures++; $display("FAIL abort_next_result got %h expected 3fc00000", r); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL abort_next_latency got %0d expected 5", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpsubber.md
Name: fpsubber

Overview:
- Multi-cycle IEEE-754 single-precision subtractor. Computes diff = a - b.
- Inverse-operation companion to fpadder on the same datapath bus. Uses the same operand/result/ready interface style, so the same benches and drivers can exercise both.
- Fixed latency, one operation in flight, result held until the next operation completes.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width
- GRS_W, 3, guard/round/sticky bits kept through alignment

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- a  input  32  minuend, IEEE-754 single
- b  input  32  subtrahend, IEEE-754 single
- busy  output  1  high from the cycle after start is accepted until ready
- diff  output  32  result, held stable between operations
- ready  output  1  one-cycle pulse when diff is updated

Behaviour:
- Reset (synchronous, active high):
  - state=IDLE, busy=0, ready=0, diff=32'h0000_0000.
  - Reset mid-operation aborts the operation; no ready pulse is produced.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE.
  - One cycle per state. No stalls.
- Timing:
  - The edge where start=1 is seen in IDLE captures a and b.
  - Exactly 5 edges later: diff updated, ready=1 for one cycle, busy=0.
  - start can be accepted again in the same cycle ready is high (back-to-back throughput: 1 op per 5 cycles).
  - start while busy=1 is ignored. Captured operands are not disturbed.
- UNPACK:
  - Split sign, exponent and mantissa; invert b's sign.
  - Insert hidden bit. Exponent 0 means zero: denormals flush to zero on input.
- ALIGN:
  - Swap so the larger magnitude is operand X.
  - Right-shift Y's mantissa by the exponent difference.
  - Shifted-out bits OR into sticky. A shift of 27 or more leaves only sticky.
- ADDSUB:
  - If effective signs are equal, add magnitudes; otherwise subtract Y from X (always non-negative after the swap).
  - Datapath width: 1 carry + 24 + GRS_W bits.
- NORM:
  - On carry-out: right-shift 1, exponent+1, sticky absorbs the lost bit.
  - Otherwise left-shift by the leading-zero count (fp_lzc), exponent minus count.
  - Zero magnitude yields exact zero.
- ROUND:
  - Round to nearest, ties to even.
  - Mantissa overflow from rounding renormalizes, exponent+1.
  - Exponent >= 255 gives ±inf. Exponent <= 0 flushes to signed zero.
- Sign rules:
  - Exact zero result from x - x is +0.
  - (-0) - (+0) = -0.
  - (+0) - (+0) = +0.
- Specials, resolved in UNPACK and carried through the pipeline to keep latency fixed:
  - Any NaN input gives 32'h7FC0_0000.
  - inf - inf with the same sign gives 32'h7FC0_0000.
  - inf - finite gives inf with a's sign.
  - finite - inf gives inf with b's sign inverted.

Decomposition:
- Package fp_pkg:
  - EXP_W, MAN_W, BIAS=127, QNAN=32'h7FC0_0000
  - state enum (IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND)
  - unpacked-operand struct {sign, exp, man, is_zero, is_inf, is_nan}
  - Shared with fpadder.
- Sub-module fp_lzc: combinational 28-bit leading-zero counter, 5-bit count output. Reused by fpadder normalisation.

Test Plan:
- Reset, then start with a=32'h4040_0000 (3.0), b=32'h3FC0_0000 (1.5) -> ready exactly 5 cycles later, diff=32'h3FC0_0000, busy low that cycle.
- a=32'h3FC0_0000, b=32'h4040_0000 -> diff=32'hBFC0_0000 (-1.5). Then a=b=32'h4040_0000 -> diff=32'h0000_0000 (+0).
- Rounding:
  - a=32'h3F80_0000, b=32'h3380_0000 -> diff=32'h3F7F_FFFF (exact).
  - a=32'h3F80_0000, b=32'h3300_0000 -> diff=32'h3F80_0000 (tie to even).
- Specials:
  - a=b=32'h7F80_0000 -> 32'h7FC0_0000.
  - a=32'hFF7F_FFFF, b=32'h7F7F_FFFF -> 32'hFF80_0000 (overflow to -inf).
  - a=32'h7FC0_0001 -> 32'h7FC0_0000.
- Protocol:
  - Second start pulse 2 cycles after first -> ignored; only one ready, result of the first operands.
  - start on the ready cycle -> accepted; next ready 5 cycles later.
- Assert reset 3 cycles into an operation -> no ready pulse, diff=0, busy=0. The next start completes normally.
